// File: rtl/peak_window_scheduler_if.sv
// Bus for the peak-window scheduler: time load/tick and window config in, clock and peak flags out.
interface peak_window_scheduler_if #(
    parameter int NUM_WIN = 3,
    parameter int IDX_W   = 2
);
    logic               min_tick;
    logic               time_load;
    logic [4:0]         hour_in;
    logic [5:0]         min_in;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [10:0]        cfg_start;
    logic [10:0]        cfg_end;
    logic               cfg_en;
    logic [4:0]         hour;
    logic [5:0]         minute;
    logic               pm;
    logic               peak;
    logic [NUM_WIN-1:0] peak_mask;
    logic               peak_rise;
    logic               peak_fall;
    logic               cfg_err;

    modport master (
        output min_tick, time_load, hour_in, min_in,
        output cfg_we, cfg_idx, cfg_start, cfg_end, cfg_en,
        input  hour, minute, pm, peak, peak_mask, peak_rise, peak_fall, cfg_err
    );

    modport slave (
        input  min_tick, time_load, hour_in, min_in,
        input  cfg_we, cfg_idx, cfg_start, cfg_end, cfg_en,
        output hour, minute, pm, peak, peak_mask, peak_rise, peak_fall, cfg_err
    );
endinterface

// File: rtl/peak_window_scheduler.sv
// Time-of-day clock with NUM_WIN programmable peak windows driving peak flag, mask and edge pulses.
// Latency: time updates on the tick/load edge; peak/mask/edges one cycle later; cfg_err one cycle after request.
// Backpressure: none; every tick and request is consumed in the cycle it is presented.
module peak_window_scheduler #(
    parameter int NUM_WIN = 3,
    parameter int IDX_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    peak_window_scheduler_if.slave  bus
);

    typedef struct packed {
        logic        en;
        logic [10:0] start;
        logic [10:0] stop;
    } win_t;

    function automatic win_t win_default(input int i);
        win_t w;
        w = '0;
        case (i)
            0:       w = '{en: 1'b1, start: 11'd420,  stop: 11'd540};
            1:       w = '{en: 1'b1, start: 11'd720,  stop: 11'd840};
            2:       w = '{en: 1'b1, start: 11'd1020, stop: 11'd1140};
            default: w = '0;
        endcase
        return w;
    endfunction

    win_t               win [NUM_WIN];
    logic [4:0]         hour_q;
    logic [5:0]         min_q;
    logic [10:0]        tod_q;
    logic [NUM_WIN-1:0] mask_q;
    logic               peak_q;
    logic               rise_q;
    logic               fall_q;
    logic               err_q;

    logic               time_ok;
    logic               cfg_ok;
    logic [10:0]        load_tod;
    logic [NUM_WIN-1:0] mask_nxt;

    assign time_ok  = (bus.hour_in <= 5'd23) && (bus.min_in <= 6'd59);
    assign cfg_ok   = (int'(bus.cfg_idx) < NUM_WIN) &&
                      (bus.cfg_start <= 11'd1439) && (bus.cfg_end <= 11'd1439);
    assign load_tod = 11'(bus.hour_in) * 11'd60 + 11'(bus.min_in);

    // A window with start > stop wraps past midnight; start == stop never matches.
    always_comb begin
        mask_nxt = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (win[i].en && (win[i].start != win[i].stop)) begin
                if (win[i].start < win[i].stop)
                    mask_nxt[i] = (tod_q >= win[i].start) && (tod_q < win[i].stop);
                else
                    mask_nxt[i] = (tod_q >= win[i].start) || (tod_q < win[i].stop);
            end
        end
    end

    // A load always takes precedence and swallows a coincident tick, even when rejected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hour_q <= '0;
            min_q  <= '0;
            tod_q  <= '0;
        end else if (bus.time_load) begin
            if (time_ok) begin
                hour_q <= bus.hour_in;
                min_q  <= bus.min_in;
                tod_q  <= load_tod;
            end
        end else if (bus.min_tick) begin
            tod_q <= (tod_q == 11'd1439) ? 11'd0 : tod_q + 11'd1;
            if (min_q == 6'd59) begin
                min_q  <= '0;
                hour_q <= (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
                min_q <= min_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_WIN; i++)
                win[i] <= win_default(i);
        end else if (bus.cfg_we && cfg_ok) begin
            for (int i = 0; i < NUM_WIN; i++)
                if (int'(bus.cfg_idx) == i)
                    win[i] <= '{en: bus.cfg_en, start: bus.cfg_start, stop: bus.cfg_end};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
            peak_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            mask_q <= mask_nxt;
            peak_q <= |mask_nxt;
            rise_q <= (|mask_nxt) & ~peak_q;
            fall_q <= ~(|mask_nxt) & peak_q;
            err_q  <= (bus.time_load & ~time_ok) | (bus.cfg_we & ~cfg_ok);
        end
    end

    assign bus.hour      = hour_q;
    assign bus.minute    = min_q;
    assign bus.pm        = (hour_q >= 5'd12);
    assign bus.peak      = peak_q;
    assign bus.peak_mask = mask_q;
    assign bus.peak_rise = rise_q;
    assign bus.peak_fall = fall_q;
    assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_peak_window_scheduler.sv
// Directed bench for peak_window_scheduler: hand-computed expectations checked with immediate assertions.
module tb_peak_window_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    peak_window_scheduler_if #(.NUM_WIN(3), .IDX_W(2)) bus ();

    peak_window_scheduler #(.NUM_WIN(3), .IDX_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        bus.min_tick = 1'b1;
        repeat (n) step();
        bus.min_tick = 1'b0;
    endtask

    task automatic load(input int h, input int m);
        bus.time_load = 1'b1;
        bus.hour_in   = 5'(h);
        bus.min_in    = 6'(m);
        step();
        bus.time_load = 1'b0;
    endtask

    task automatic cfg(input int idx, input int s, input int e, input logic en);
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = 2'(idx);
        bus.cfg_start = 11'(s);
        bus.cfg_end   = 11'(e);
        bus.cfg_en    = en;
        step();
        bus.cfg_we    = 1'b0;
    endtask

    initial begin
        bus.min_tick  = 1'b0;
        bus.time_load = 1'b0;
        bus.hour_in   = '0;
        bus.min_in    = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_idx   = '0;
        bus.cfg_start = '0;
        bus.cfg_end   = '0;
        bus.cfg_en    = 1'b0;

        step();
        chk("rst_hour",  bus.hour, 0);
        chk("rst_min",   bus.minute, 0);
        chk("rst_pm",    bus.pm, 0);
        chk("rst_peak",  bus.peak, 0);
        chk("rst_mask",  bus.peak_mask, 0);
        chk("rst_rise",  bus.peak_rise, 0);
        chk("rst_fall",  bus.peak_fall, 0);
        chk("rst_err",   bus.cfg_err, 0);
        rst = 1'b0;

        tick_n(1);
        chk("first_tick_min",  bus.minute, 1);
        chk("first_tick_hour", bus.hour, 0);

        // 06:59 -> 07:00 enters default window 0
        load(6, 59);
        chk("load_0659_hour", bus.hour, 6);
        chk("load_0659_min",  bus.minute, 59);
        tick_n(1);
        chk("t0700_hour", bus.hour, 7);
        chk("t0700_min",  bus.minute, 0);
        chk("t0700_peak_lag", bus.peak, 0);
        step();
        chk("t0700_peak", bus.peak, 1);
        chk("t0700_rise", bus.peak_rise, 1);
        chk("t0700_mask", bus.peak_mask, 3'b001);
        step();
        chk("t0700_rise_once", bus.peak_rise, 0);
        chk("t0700_peak_hold", bus.peak, 1);

        // 08:59 -> 09:00 leaves window 0
        load(8, 59);
        tick_n(1);
        chk("t0900_hour", bus.hour, 9);
        step();
        chk("t0900_peak", bus.peak, 0);
        chk("t0900_fall", bus.peak_fall, 1);
        chk("t0900_pm",   bus.pm, 0);
        step();
        chk("t0900_fall_once", bus.peak_fall, 0);

        // Window 1 spans midnight: 22:00..02:00
        cfg(1, 1320, 120, 1'b1);
        chk("cfg_w1_err", bus.cfg_err, 0);
        load(21, 59);
        tick_n(1);
        step();
        chk("t2200_peak", bus.peak, 1);
        chk("t2200_rise", bus.peak_rise, 1);
        chk("t2200_mask", bus.peak_mask, 3'b010);
        tick_n(119);
        chk("t2359_hour", bus.hour, 23);
        chk("t2359_min",  bus.minute, 59);
        chk("t2359_pm",   bus.pm, 1);
        chk("t2359_peak", bus.peak, 1);
        tick_n(1);
        chk("t0000_hour", bus.hour, 0);
        chk("t0000_min",  bus.minute, 0);
        chk("t0000_pm",   bus.pm, 0);
        step();
        chk("t0000_peak", bus.peak, 1);
        chk("t0000_fall", bus.peak_fall, 0);
        chk("t0000_mask", bus.peak_mask, 3'b010);
        tick_n(120);
        chk("t0200_hour", bus.hour, 2);
        chk("t0200_min",  bus.minute, 0);
        chk("t0200_peak_lag", bus.peak, 1);
        step();
        chk("t0200_peak", bus.peak, 0);
        chk("t0200_fall", bus.peak_fall, 1);

        // Load beats a coincident tick
        bus.min_tick = 1'b1;
        load(12, 30);
        bus.min_tick = 1'b0;
        chk("ld_tick_hour", bus.hour, 12);
        chk("ld_tick_min",  bus.minute, 30);
        chk("ld_tick_pm",   bus.pm, 1);
        chk("ld_tick_err",  bus.cfg_err, 0);
        load(24, 0);
        chk("bad_hour_err",  bus.cfg_err, 1);
        chk("bad_hour_hour", bus.hour, 12);
        chk("bad_hour_min",  bus.minute, 30);
        step();
        chk("bad_hour_err_once", bus.cfg_err, 0);
        load(10, 60);
        chk("bad_min_err", bus.cfg_err, 1);
        chk("bad_min_hour", bus.hour, 12);

        // Out-of-range index and end are rejected; an accepted write would cover 12:30
        cfg(3, 0, 1439, 1'b1);
        chk("bad_idx_err", bus.cfg_err, 1);
        step();
        chk("bad_idx_mask", bus.peak_mask, 0);
        chk("bad_idx_err_once", bus.cfg_err, 0);
        cfg(0, 0, 1440, 1'b1);
        chk("bad_end_err", bus.cfg_err, 1);
        step();
        chk("bad_end_mask", bus.peak_mask, 0);

        // Config writes at 12:00
        cfg(1, 720, 840, 1'b1);
        load(12, 0);
        step();
        chk("t1200_peak", bus.peak, 1);
        chk("t1200_mask", bus.peak_mask, 3'b010);
        cfg(1, 720, 720, 1'b1);
        step();
        chk("eq_win_peak", bus.peak, 0);
        chk("eq_win_fall", bus.peak_fall, 1);
        cfg(2, 700, 800, 1'b0);
        step();
        chk("dis_w2_mask", bus.peak_mask, 0);
        chk("dis_w2_peak", bus.peak, 0);

        // Valid write alongside a rejected load: write lands, one error pulse
        bus.cfg_we    = 1'b1;
        bus.cfg_idx   = 2'd2;
        bus.cfg_start = 11'd700;
        bus.cfg_end   = 11'd800;
        bus.cfg_en    = 1'b1;
        load(25, 0);
        bus.cfg_we    = 1'b0;
        chk("mix_err",  bus.cfg_err, 1);
        chk("mix_hour", bus.hour, 12);
        step();
        chk("mix_err_once", bus.cfg_err, 0);
        chk("mix_mask", bus.peak_mask, 3'b100);
        chk("mix_rise", bus.peak_rise, 1);

        // Reset in the middle of a peak
        load(7, 30);
        step();
        chk("t0730_peak", bus.peak, 1);
        chk("t0730_mask", bus.peak_mask, 3'b001);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_hour", bus.hour, 0);
        chk("arst_min",  bus.minute, 0);
        chk("arst_peak", bus.peak, 0);
        chk("arst_mask", bus.peak_mask, 0);
        chk("arst_fall", bus.peak_fall, 0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_fall", bus.peak_fall, 0);
        chk("post_rst_rise", bus.peak_rise, 0);
        load(12, 10);
        step();
        chk("dflt_w1_mask", bus.peak_mask, 3'b010);
        load(17, 0);
        step();
        chk("dflt_w2_mask", bus.peak_mask, 3'b100);
        load(8, 0);
        step();
        chk("dflt_w0_mask", bus.peak_mask, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
